// File: rtl/amo_wr_arbiter.sv
// Round-robin arbiter for AMO write-back requests from NUM_CORES cores onto one
// shared-memory write port; the winning payload is registered and held until accepted.
module amo_wr_arbiter #(
  parameter  int NUM_CORES = 2,
  localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CORES-1:0]   req_i,
  input  logic [NUM_CORES*32-1:0] addr_i,
  input  logic [NUM_CORES*32-1:0] wdata_i,
  input  logic [NUM_CORES*4-1:0] mask_i,
  output logic [NUM_CORES-1:0]   ack_o,
  output logic [NUM_CORES-1:0]   stall_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_wdata_o,
  output logic [3:0]             mem_mask_o,
  input  logic                   mem_ready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_found;
  logic             any_req;
  logic             fire;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic [3:0]       win_mask;

  // Round-robin pick: the lowest requester at or above rr_ptr wins; if there is
  // none, the search wraps and the lowest requester overall wins.
  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        lo_idx = IDX_W'(k);
        if (k >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(k);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_mask  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_addr  = addr_i[32*k +: 32];
        win_wdata = wdata_i[32*k +: 32];
        win_mask  = mask_i[4*k +: 4];
      end
    end
  end

  assign any_req = |req_i;
  assign fire    = (state == BUSY) && mem_ready_i;

  // Modulo increment that also wraps correctly for non-power-of-2 core counts.
  assign rr_next = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;

  always_comb begin
    ack_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      ack_o[k] = fire && (grant_idx == IDX_W'(k));
    end
  end

  assign stall_o = req_i & ~ack_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_mask_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx   <= win_idx;
            mem_addr_o  <= win_addr;
            mem_wdata_o <= win_wdata;
            mem_mask_o  <= win_mask;
            mem_we_o    <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // Payload is frozen here; late payload changes from the requester are ignored.
          if (mem_ready_i) begin
            mem_we_o <= 1'b0;
            rr_ptr   <= rr_next;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amo_wr_arbiter.sv
// Directed bench for amo_wr_arbiter: a 2-core and a 3-core instance driven by
// hand-written cycle steps with hand-computed expected outputs.
module tb_amo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic [1:0]  req2;
  logic [63:0] addr2;
  logic [63:0] wdata2;
  logic [7:0]  mask2;
  logic        ready2;
  logic [1:0]  ack2;
  logic [1:0]  stall2;
  logic        we2;
  logic [31:0] maddr2;
  logic [31:0] mwdata2;
  logic [3:0]  mmask2;

  logic [2:0]  req3;
  logic [95:0] addr3;
  logic [95:0] wdata3;
  logic [11:0] mask3;
  logic        ready3;
  logic [2:0]  ack3;
  logic [2:0]  stall3;
  logic        we3;
  logic [31:0] maddr3;
  logic [31:0] mwdata3;
  logic [3:0]  mmask3;

  int vectors    = 0;
  int miscompares = 0;

  amo_wr_arbiter #(.NUM_CORES(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req2),
    .addr_i      (addr2),
    .wdata_i     (wdata2),
    .mask_i      (mask2),
    .ack_o       (ack2),
    .stall_o     (stall2),
    .mem_we_o    (we2),
    .mem_addr_o  (maddr2),
    .mem_wdata_o (mwdata2),
    .mem_mask_o  (mmask2),
    .mem_ready_i (ready2)
  );

  amo_wr_arbiter #(.NUM_CORES(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req3),
    .addr_i      (addr3),
    .wdata_i     (wdata3),
    .mask_i      (mask3),
    .ack_o       (ack3),
    .stall_o     (stall3),
    .mem_we_o    (we3),
    .mem_addr_o  (maddr3),
    .mem_wdata_o (mwdata3),
    .mem_mask_o  (mmask3),
    .mem_ready_i (ready3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_ack;
    logic [1:0] exp_req;

    // Reset with both 2-core requesters active
    rst_n  = 1'b0;
    req2   = 2'b11;
    addr2  = {32'h2000_0100, 32'h1000_0000};
    wdata2 = {32'h2222_2222, 32'h1111_1111};
    mask2  = {4'b1100, 4'b0011};
    ready2 = 1'b0;
    req3   = 3'b000;
    addr3  = {32'h3000_0020, 32'h3000_0010, 32'h3000_0000};
    wdata3 = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    mask3  = {4'b0100, 4'b0010, 4'b0001};
    ready3 = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    check("rst_we",    32'(we2),     32'h0);
    check("rst_addr",  maddr2,       32'h0);
    check("rst_wdata", mwdata2,      32'h0);
    check("rst_mask",  32'(mmask2),  32'h0);
    check("rst_ack",   32'(ack2),    32'h0);
    check("rst_stall", 32'(stall2),  32'h3);

    // Single request from core1 with memory ready
    next_cycle();
    rst_n = 1'b1;
    req2  = 2'b00;
    next_cycle();
    req2   = 2'b10;
    addr2  = {32'h1000_0040, 32'h0BAD_0000};
    wdata2 = {32'hDEAD_BEEF, 32'h0000_0BAD};
    mask2  = {4'b1111, 4'b0001};
    ready2 = 1'b1;
    sample();
    check("single_pre_we", 32'(we2), 32'h0);
    next_cycle();
    sample();
    check("single_we",    32'(we2),    32'h1);
    check("single_addr",  maddr2,      32'h1000_0040);
    check("single_wdata", mwdata2,     32'hDEAD_BEEF);
    check("single_mask",  32'(mmask2), 32'hF);
    check("single_ack",   32'(ack2),   32'h2);
    check("single_stall", 32'(stall2), 32'h0);
    next_cycle();
    req2 = 2'b00;
    sample();
    check("single_we_drop", 32'(we2),  32'h0);
    check("single_ack_end", 32'(ack2), 32'h0);

    // Contention from reset: grants 0,1,0,1 with acks two cycles apart
    next_cycle();
    rst_n  = 1'b0;
    req2   = 2'b11;
    addr2  = {32'h2000_0100, 32'h1000_0000};
    wdata2 = {32'h2222_2222, 32'h1111_1111};
    mask2  = {4'b1100, 4'b0011};
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      if (i == 7) req2 = 2'b00;
      sample();
      exp_req = (i == 7) ? 2'b00 : 2'b11;
      if (i % 2 == 1)          exp_ack = 2'b00;
      else if ((i / 2) % 2 == 0) exp_ack = 2'b01;
      else                     exp_ack = 2'b10;
      check($sformatf("rr_ack_%0d", i),   32'(ack2),   32'(exp_ack));
      check($sformatf("rr_stall_%0d", i), 32'(stall2), 32'(exp_req & ~exp_ack));
      check($sformatf("rr_we_%0d", i),    32'(we2),    (i % 2 == 0) ? 32'h1 : 32'h0);
      if (i % 2 == 0)
        check($sformatf("rr_addr_%0d", i), maddr2,
              ((i / 2) % 2 == 0) ? 32'h1000_0000 : 32'h2000_0100);
    end

    // Backpressure: core0 held 6 cycles, core1 rises while busy, core1 has a zero mask
    next_cycle();
    req2   = 2'b01;
    ready2 = 1'b0;
    addr2  = {32'h2000_0200, 32'h1000_0080};
    wdata2 = {32'h5555_AAAA, 32'hA5A5_0001};
    mask2  = {4'b0000, 4'b0110};
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 2) req2 = 2'b11;
      if (c == 3) wdata2[31:0] = 32'hFFFF_FFFF;
      if (c == 6) ready2 = 1'b1;
      sample();
      check($sformatf("bp_we_%0d", c),    32'(we2),    32'h1);
      check($sformatf("bp_addr_%0d", c),  maddr2,      32'h1000_0080);
      check($sformatf("bp_wdata_%0d", c), mwdata2,     32'hA5A5_0001);
      check($sformatf("bp_mask_%0d", c),  32'(mmask2), 32'h6);
      check($sformatf("bp_ack_%0d", c),   32'(ack2),   (c == 6) ? 32'h1 : 32'h0);
      check($sformatf("bp_stall_%0d", c), 32'(stall2),
            (c == 1) ? 32'h1 : ((c == 6) ? 32'h2 : 32'h3));
    end
    next_cycle();
    req2 = 2'b10;
    sample();
    check("bp_idle_we",    32'(we2),    32'h0);
    check("bp_idle_ack",   32'(ack2),   32'h0);
    check("bp_idle_stall", 32'(stall2), 32'h2);
    next_cycle();
    sample();
    check("bp_c1_ack",  32'(ack2),   32'h2);
    check("bp_c1_addr", maddr2,      32'h2000_0200);
    check("bp_c1_mask", 32'(mmask2), 32'h0);
    next_cycle();
    req2 = 2'b00;
    sample();
    check("bp_end_we", 32'(we2), 32'h0);

    // Reset mid-transaction: move rr_ptr to 1, then abort a core0 grant
    next_cycle();
    req2 = 2'b01;
    next_cycle();
    sample();
    check("mid_first_ack", 32'(ack2), 32'h1);
    next_cycle();
    ready2 = 1'b0;
    next_cycle();
    sample();
    check("mid_busy_we",  32'(we2),  32'h1);
    check("mid_busy_ack", 32'(ack2), 32'h0);
    next_cycle();
    rst_n = 1'b0;
    sample();
    check("mid_rst_ack", 32'(ack2), 32'h0);
    next_cycle();
    rst_n  = 1'b1;
    req2   = 2'b11;
    ready2 = 1'b1;
    sample();
    check("mid_after_we",   32'(we2),  32'h0);
    check("mid_after_ack",  32'(ack2), 32'h0);
    check("mid_after_addr", maddr2,    32'h0);
    next_cycle();
    sample();
    check("mid_regrant_ack",  32'(ack2), 32'h1);
    check("mid_regrant_addr", maddr2,    32'h1000_0080);
    next_cycle();
    req2 = 2'b00;

    // Three cores: core2 alone, then wrap to core0 before core1
    req3   = 3'b100;
    ready3 = 1'b1;
    next_cycle();
    sample();
    check("n3_c2_ack",  32'(ack3), 32'h4);
    check("n3_c2_addr", maddr3,    32'h3000_0020);
    next_cycle();
    req3 = 3'b011;
    sample();
    check("n3_idle1_ack",   32'(ack3),   32'h0);
    check("n3_idle1_stall", 32'(stall3), 32'h3);
    next_cycle();
    sample();
    check("n3_c0_ack",   32'(ack3),   32'h1);
    check("n3_c0_stall", 32'(stall3), 32'h2);
    check("n3_c0_data",  mwdata3,     32'hC0DE_0000);
    next_cycle();
    req3 = 3'b111;
    sample();
    check("n3_idle2_we", 32'(we3), 32'h0);
    next_cycle();
    sample();
    check("n3_c1_ack", 32'(ack3), 32'h2);
    next_cycle();
    sample();
    check("n3_idle3_ack", 32'(ack3), 32'h0);
    next_cycle();
    sample();
    check("n3_c2b_ack",  32'(ack3),   32'h4);
    check("n3_c2b_mask", 32'(mmask3), 32'h4);
    next_cycle();
    next_cycle();
    req3 = 3'b000;
    sample();
    check("n3_c0b_ack", 32'(ack3), 32'h1);
    next_cycle();
    sample();
    check("n3_end_we", 32'(we3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/amo_wr_arbiter.md
Name: amo_wr_arbiter

Overview:
- Arbitrates AMO write-back requests from NUM_CORES core write-back stages onto the single shared-memory write port.
- Each core's write-back stage presents amo_mem_wr_req, mask, core_out_mem_addr_in and core_out_mem_data_in.
- The block grants one requester at a time using round-robin priority, registers the winning payload and holds it until the memory accepts it.
- On acceptance it returns a one-cycle ack to the winner and stalls all other requesters.

Parameters:
- NUM_CORES, 2, number of requesting cores (>=1).
- IDX_W, $clog2(NUM_CORES) with minimum 1, width of the grant index and round-robin pointer (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_i  in  NUM_CORES  per-core AMO write request (amo_mem_wr_req).
- addr_i  in  NUM_CORES*32  per-core byte address; core k occupies bits [32k+31:32k].
- wdata_i  in  NUM_CORES*32  per-core write data, packed as for addr_i.
- mask_i  in  NUM_CORES*4  per-core byte-enable mask; core k occupies bits [4k+3:4k].
- ack_o  out  NUM_CORES  one-cycle pulse; the write of core k has been accepted by memory.
- stall_o  out  NUM_CORES  core k must hold its write-back stage.
- mem_we_o  out  1  write request to shared memory.
- mem_addr_o  out  32  registered write address.
- mem_wdata_o  out  32  registered write data.
- mem_mask_o  out  4  registered byte mask.
- mem_ready_i  in  1  memory accepts the current write this cycle.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_mask_o=0.
  - ack_o=0; stall_o follows req_i because no grant is active.
- Reset asserted while BUSY aborts the transaction: no ack is issued, mem_we_o=0 on the next cycle, and the requester must re-request.
- Requester contract:
  - req_i[k] and its payload stay stable from assertion until the cycle ack_o[k]=1.
  - The requester drops req_i or presents a new request the following cycle.
  - Payload changes before ack are a protocol violation; the arbiter ignores them because the payload was latched at grant.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req_i has any bit set, search from index rr_ptr upward with wrap-around; the first set bit wins (g).
  - Latch addr/wdata/mask of g into the mem_*_o registers, set grant_idx=g and mem_we_o=1, and go to BUSY.
  - If no bit is set, stay in IDLE with mem_we_o=0. Payload registers hold their last value.
- BUSY:
  - mem_we_o=1 and the payload outputs are held stable.
  - If mem_ready_i=1:
    - ack_o[grant_idx]=1 combinationally in this cycle.
    - rr_ptr <= (grant_idx+1) mod NUM_CORES.
    - Next state is IDLE, with mem_we_o=0 next cycle.
  - If mem_ready_i=0, stay in BUSY indefinitely; no timeout.
- ack_o = onehot(grant_idx) & {NUM_CORES{state==BUSY && mem_ready_i}}.
- stall_o[k] = req_i[k] & ~ack_o[k].
- Latency: a request seen in IDLE at cycle t gives mem_we_o at t+1. With mem_ready_i=1 at t+1, ack is at t+1.
- Throughput: at most one write per 2 cycles; the mandatory IDLE cycle re-arbitrates.
- A request that rises while BUSY waits for the next IDLE cycle.
- Fairness: a continuously requesting core is granted within NUM_CORES grants.
- Wrap: rr_ptr increments modulo NUM_CORES, including non-power-of-2 values (e.g. 3 cores: 2→0).
- mask_i=4'b0000 is forwarded unchanged and acked normally; no filtering.
- NUM_CORES=1: rr_ptr stays 0 and the block degenerates to a register stage plus handshake.
- A simultaneous req_i drop by a non-granted core has no effect; the granted core cannot drop before ack.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_i=2'b11 → all mem_*_o=0, ack_o=0, stall_o=2'b11, state IDLE; then release.
- Single request, memory ready:
  - Stimulus: core1 req with addr=0x1000_0040, wdata=0xDEAD_BEEF, mask=4'b1111, mem_ready_i=1.
  - Required: next cycle mem_we_o=1 with those values and ack_o=2'b10 in the same cycle; mem_we_o=0 the cycle after.
- Contention, round-robin:
  - Stimulus: both cores request continuously from reset.
  - Required: grant order core0, core1, core0, core1; each ack 2 cycles apart; the non-granted core has stall_o=1 throughout.
- Memory backpressure:
  - Stimulus: core0 req, mem_ready_i=0 for 5 cycles, then 1.
  - Required: mem_we_o and payload stay constant for 6 cycles; ack_o[0] only in cycle 6; core1 requesting meanwhile is not granted until the following IDLE cycle.
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 while BUSY with mem_ready_i=0.
  - Required: no ack_o pulse, mem_we_o=0 and rr_ptr=0 next cycle; a re-issued request is granted normally.
- NUM_CORES=3 wrap:
  - Stimulus: only core2 requests, then cores 0 and 1 request.
  - Required: core2 granted, rr_ptr wraps to 0, core0 granted before core1.
